// File: rtl/cgra_config_streamer.sv
// Buffers (addr, data, last) config words from a host/DMA source and replays them to the CGRA
// config port one per clock. Optional parity checking at push is enabled by CGRA_CFG_PARITY_EN.
module cgra_config_streamer #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              start_in,
  input  logic              abort_in,
  input  logic              cfg_valid_in,
  output logic              cfg_ready_out,
  input  logic [ADDR_W-1:0] cfg_addr_in,
  input  logic [DATA_W-1:0] cfg_data_in,
  input  logic              cfg_last_in,
  output logic [ADDR_W-1:0] config_addr_out,
  output logic [DATA_W-1:0] config_data_out,
  output logic              config_done_out,
  output logic [CNT_W-1:0]  word_count_out,
`ifdef CGRA_CFG_PARITY_EN
  input  logic              cfg_parity_in,
  output logic              parity_err_out,
`endif
  output logic [1:0]        dbg_state_out
);

  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                ready_q, ready_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic [ADDR_W-1:0]   addr_mem [FIFO_DEPTH];
  logic [DATA_W-1:0]   data_mem [FIFO_DEPTH];
  logic                last_mem [FIFO_DEPTH];

  logic                empty, full_d, push_hs, push_store, pop;
  logic [ADDR_W-1:0]   wr_addr, head_addr;
  logic [DATA_W-1:0]   wr_data, head_data;
  logic                head_last;

  // Handshake: a word transfers on a rising edge where cfg_valid_in && cfg_ready_out.
  // cfg_ready_out is a register and never looks at cfg_valid_in; an abort in the same
  // cycle discards the transfer.
  assign push_hs   = cfg_valid_in && ready_q && !abort_in;
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign pop       = (state_q == ST_STREAM) && !empty && !abort_in;
  assign head_addr = addr_mem[rd_ptr_q[IDX_W-1:0]];
  assign head_data = data_mem[rd_ptr_q[IDX_W-1:0]];
  assign head_last = last_mem[rd_ptr_q[IDX_W-1:0]];

`ifdef CGRA_CFG_PARITY_EN
  logic par_ok, parity_err_q, parity_err_d;
  assign par_ok     = ((^{cfg_addr_in, cfg_data_in}) == cfg_parity_in);
  // A bad word is dropped unless it carries last; then it becomes an addr-0 marker.
  assign push_store = push_hs && (par_ok || cfg_last_in);
  assign wr_addr    = par_ok ? cfg_addr_in : '0;
  assign wr_data    = par_ok ? cfg_data_in : '0;

  always_comb begin
    parity_err_d = parity_err_q;
    if (abort_in || start_in) parity_err_d = 1'b0;
    if (push_hs && !par_ok)   parity_err_d = 1'b1;
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) parity_err_q <= 1'b0;
    else           parity_err_q <= parity_err_d;
  end

  assign parity_err_out = parity_err_q;
`else
  assign push_store = push_hs;
  assign wr_addr    = cfg_addr_in;
  assign wr_data    = cfg_data_in;
`endif

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q + PTR_W'(push_store);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    addr_d   = '0;
    data_d   = '0;
    count_d  = count_q;
    if (abort_in) begin
      state_d  = ST_IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_in) begin
            state_d = ST_STREAM;
            count_d = '0;
          end
        end
        ST_STREAM: begin
          if (pop) begin
            if (head_addr != '0) begin
              addr_d = head_addr;
              data_d = head_data;
              if (count_q != {CNT_W{1'b1}}) count_d = count_q + 1'b1;
            end
            if (head_last) state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    full_d  = (wr_ptr_d[IDX_W] != rd_ptr_d[IDX_W]) &&
              (wr_ptr_d[IDX_W-1:0] == rd_ptr_d[IDX_W-1:0]);
    ready_d = !full_d && (state_d != ST_DONE);
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ready_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= ready_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy is defined entirely by the pointers.
  always_ff @(posedge clk_in) begin
    if (push_store) begin
      addr_mem[wr_ptr_q[IDX_W-1:0]] <= wr_addr;
      data_mem[wr_ptr_q[IDX_W-1:0]] <= wr_data;
      last_mem[wr_ptr_q[IDX_W-1:0]] <= cfg_last_in;
    end
  end

  assign cfg_ready_out   = ready_q;
  assign config_addr_out = addr_q;
  assign config_data_out = data_q;
  assign config_done_out = (state_q == ST_DONE);
  assign word_count_out  = count_q;
  assign dbg_state_out   = state_q;

endmodule

// File: tb/tb_cgra_config_streamer.sv
// Directed bench for cgra_config_streamer: stimulus pushes expected emissions into a queue,
// a negedge monitor pops and compares every non-zero config word.
module tb_cgra_config_streamer;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        start_in, abort_in;
  logic        cfg_valid_in, cfg_ready_out;
  logic [31:0] cfg_addr_in, cfg_data_in;
  logic        cfg_last_in;
  logic [31:0] config_addr_out, config_data_out;
  logic        config_done_out;
  logic [15:0] word_count_out;
  logic [1:0]  dbg_state_out;
`ifdef CGRA_CFG_PARITY_EN
  logic        cfg_parity_in;
  logic        parity_err_out;
`endif

  int vectors     = 0;
  int miscompares = 0;
  logic [63:0] exp_q[$];

  cgra_config_streamer dut (
    .clk_in          (clk_in),
    .reset_in        (reset_in),
    .start_in        (start_in),
    .abort_in        (abort_in),
    .cfg_valid_in    (cfg_valid_in),
    .cfg_ready_out   (cfg_ready_out),
    .cfg_addr_in     (cfg_addr_in),
    .cfg_data_in     (cfg_data_in),
    .cfg_last_in     (cfg_last_in),
    .config_addr_out (config_addr_out),
    .config_data_out (config_data_out),
    .config_done_out (config_done_out),
    .word_count_out  (word_count_out),
`ifdef CGRA_CFG_PARITY_EN
    .cfg_parity_in   (cfg_parity_in),
    .parity_err_out  (parity_err_out),
`endif
    .dbg_state_out   (dbg_state_out)
  );

  // Clock and watchdog
  always #5 clk_in = ~clk_in;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard monitor
  always @(negedge clk_in) begin
    if (reset_in && config_addr_out != 32'h0) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_emit: got addr=%0h data=%0h, required no emission",
                 config_addr_out, config_data_out);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({config_addr_out, config_data_out} !== e) begin
          miscompares++;
          $display("FAIL emit: got addr=%0h data=%0h, required addr=%0h data=%0h",
                   config_addr_out, config_data_out, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Driver tasks: called and return at a falling edge.
  task automatic drive_word(input logic [31:0] a, input logic [31:0] d, input logic l,
                            input logic bad);
    int w = 0;
    cfg_valid_in = 1'b1;
    cfg_addr_in  = a;
    cfg_data_in  = d;
    cfg_last_in  = l;
`ifdef CGRA_CFG_PARITY_EN
    cfg_parity_in = (^{a, d}) ^ bad;
`else
    if (bad) $display("note: parity corruption requested without parity build");
`endif
    while (!cfg_ready_out && w < 50) begin
      @(negedge clk_in);
      w++;
    end
    if (!cfg_ready_out) check("push_ready_timeout", 64'(cfg_ready_out), 64'h1);
    @(posedge clk_in);
    @(negedge clk_in);
    cfg_valid_in = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] a, input logic [31:0] d, input logic l);
    drive_word(a, d, l, 1'b0);
  endtask

  task automatic pulse_start();
    start_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    start_in = 1'b0;
  endtask

  task automatic pulse_abort();
    abort_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    abort_in = 1'b0;
  endtask

  initial begin
    reset_in     = 1'b0;
    start_in     = 1'b0;
    abort_in     = 1'b0;
    cfg_valid_in = 1'b0;
    cfg_addr_in  = '0;
    cfg_data_in  = '0;
    cfg_last_in  = 1'b0;
`ifdef CGRA_CFG_PARITY_EN
    cfg_parity_in = 1'b0;
`endif

    // Reset values
    #12;
    check("rst_addr",  64'(config_addr_out), 64'h0);
    check("rst_data",  64'(config_data_out), 64'h0);
    check("rst_done",  64'(config_done_out), 64'h0);
    check("rst_count", 64'(word_count_out), 64'h0);
    check("rst_ready", 64'(cfg_ready_out), 64'h0);
    check("rst_state", 64'(dbg_state_out), 64'h0);
    @(negedge clk_in);
    reset_in = 1'b1;
    @(negedge clk_in);
    check("post_rst_ready", 64'(cfg_ready_out), 64'h1);

    // Abort beats start and a same-cycle push
    cfg_valid_in = 1'b1;
    cfg_addr_in  = 32'h40;
    cfg_data_in  = 32'h1;
`ifdef CGRA_CFG_PARITY_EN
    cfg_parity_in = ^{32'h40, 32'h1};
`endif
    start_in = 1'b1;
    abort_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    cfg_valid_in = 1'b0;
    start_in     = 1'b0;
    abort_in     = 1'b0;
    check("abort_wins_state", 64'(dbg_state_out), 64'h0);
    pulse_start();
    check("start_state", 64'(dbg_state_out), 64'h1);
    repeat (3) @(negedge clk_in);
    check("discarded_push_addr", 64'(config_addr_out), 64'h0);

    // Three back-to-back words ending in last
    exp_q.push_back({32'h10, 32'hAB});
    exp_q.push_back({32'h14, 32'hCD});
    exp_q.push_back({32'h18, 32'hEF});
    push_word(32'h10, 32'hAB, 1'b0);
    push_word(32'h14, 32'hCD, 1'b0);
    push_word(32'h18, 32'hEF, 1'b1);
    check("t1_second_addr", 64'(config_addr_out), 64'h14);
    @(negedge clk_in);
    check("t1_third_addr", 64'(config_addr_out), 64'h18);
    @(negedge clk_in);
    check("t1_idle_addr", 64'(config_addr_out), 64'h0);
    check("t1_done",      64'(config_done_out), 64'h1);
    check("t1_count",     64'(word_count_out), 64'h3);
    check("t1_ready",     64'(cfg_ready_out), 64'h0);

    pulse_abort();
    check("abort_state", 64'(dbg_state_out), 64'h0);
    check("abort_done",  64'(config_done_out), 64'h0);
    check("abort_count", 64'(word_count_out), 64'h3);

    // Prefill to full in IDLE, then stream
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({32'h100 + 32'(4 * i), 32'(i + 1)});
      push_word(32'h100 + 32'(4 * i), 32'(i + 1), (i == 3));
    end
    check("prefill_full_ready", 64'(cfg_ready_out), 64'h0);
    check("prefill_no_emit",    64'(config_addr_out), 64'h0);
    pulse_start();
    check("t2_ready_before_pop", 64'(cfg_ready_out), 64'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      check("t2_emit_addr", 64'(config_addr_out), 64'h100 + 64'(4 * i));
      if (i == 0) check("t2_ready_reassert", 64'(cfg_ready_out), 64'h1);
    end
    check("t2_done",  64'(config_done_out), 64'h1);
    check("t2_count", 64'(word_count_out), 64'h4);

    // Restart from DONE; an addr-0 word is dropped and not counted
    pulse_start();
    check("t3_count_cleared", 64'(word_count_out), 64'h0);
    check("t3_done_cleared",  64'(config_done_out), 64'h0);
    exp_q.push_back({32'h20, 32'h66});
    push_word(32'h0, 32'h55, 1'b0);
    push_word(32'h20, 32'h66, 1'b1);
    repeat (3) @(negedge clk_in);
    check("t3_done",  64'(config_done_out), 64'h1);
    check("t3_count", 64'(word_count_out), 64'h1);

    // Abort with three buffered words
    pulse_abort();
    push_word(32'h30, 32'h3, 1'b0);
    push_word(32'h34, 32'h4, 1'b0);
    push_word(32'h38, 32'h5, 1'b0);
    pulse_start();
    pulse_abort();
    check("t4_abort_addr",  64'(config_addr_out), 64'h0);
    check("t4_abort_state", 64'(dbg_state_out), 64'h0);
    check("t4_count_held",  64'(word_count_out), 64'h0);
    pulse_start();
    repeat (4) @(negedge clk_in);
    check("t4_flushed_addr",  64'(config_addr_out), 64'h0);
    check("t4_flushed_state", 64'(dbg_state_out), 64'h1);

    // Asynchronous reset mid-stream
    pulse_abort();
    exp_q.push_back({32'h50, 32'h5});
    push_word(32'h50, 32'h5, 1'b0);
    push_word(32'h54, 32'h6, 1'b1);
    pulse_start();
    @(negedge clk_in);
    #2 reset_in = 1'b0;
    #1;
    check("async_rst_addr",  64'(config_addr_out), 64'h0);
    check("async_rst_data",  64'(config_data_out), 64'h0);
    check("async_rst_ready", 64'(cfg_ready_out), 64'h0);
    check("async_rst_state", 64'(dbg_state_out), 64'h0);
    @(negedge clk_in);
    reset_in = 1'b1;
    @(negedge clk_in);
    pulse_start();
    repeat (4) @(negedge clk_in);
    check("post_rst_empty_addr",  64'(config_addr_out), 64'h0);
    check("post_rst_empty_state", 64'(dbg_state_out), 64'h1);

`ifdef CGRA_CFG_PARITY_EN
    // Bad parity word dropped; sticky flag until start_in
    drive_word(32'h60, 32'h7, 1'b0, 1'b1);
    check("parity_err_set", 64'(parity_err_out), 64'h1);
    repeat (2) @(negedge clk_in);
    check("parity_err_sticky", 64'(parity_err_out), 64'h1);
    pulse_start();
    check("parity_err_cleared", 64'(parity_err_out), 64'h0);
    exp_q.push_back({32'h64, 32'h8});
    push_word(32'h64, 32'h8, 1'b0);
    repeat (2) @(negedge clk_in);
`endif

    repeat (3) @(negedge clk_in);
    check("exp_q_drained", 64'(exp_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cgra_config_streamer.md
Name: cgra_config_streamer

Overview:
- Synthesizable upstream feeder for the CGRA config port (`config_addr_in` / `config_data_in` on `top`).
- Accepts (addr, data, last) config words from a host/DMA source over a valid/ready handshake and buffers them in a small FIFO.
- Replays them to the CGRA one word per clock, driving address 0 (no-op) on idle cycles.
- Reports completion and a word count, replacing file-driven config injection in silicon and gate-level sims.

Parameters:
- ADDR_W, 32, config address width.
- DATA_W, 32, config data width.
- FIFO_DEPTH, 4, input buffer entries; power of 2, ≥2.
- CNT_W, 16, width of emitted-word counter.

Ports:
- clk_in  input  1  system clock, rising edge.
- reset_in  input  1  asynchronous, active-low reset.
- start_in  input  1  one-cycle pulse: begin/restart streaming.
- abort_in  input  1  one-cycle pulse: flush and return to idle.
- cfg_valid_in  input  1  upstream word valid.
- cfg_ready_out  output  1  streamer can accept word.
- cfg_addr_in  input  ADDR_W  upstream config address.
- cfg_data_in  input  DATA_W  upstream config data.
- cfg_last_in  input  1  marks final word of bitstream.
- config_addr_out  output  ADDR_W  to CGRA config_addr_in; 0 = no-op.
- config_data_out  output  DATA_W  to CGRA config_data_in.
- config_done_out  output  1  high while in DONE.
- word_count_out  output  CNT_W  words emitted since last start.

Behaviour:
- Reset (reset_in=0, async):
  - FIFO empty; state IDLE.
  - config_addr_out=0, config_data_out=0, config_done_out=0, word_count_out=0, cfg_ready_out=0.
  - A reset mid-stream discards all buffered words.
- cfg_ready_out = !fifo_full && state!=DONE. Registered-flag based; never combinationally dependent on cfg_valid_in.
- Push occurs on an edge where cfg_valid_in && cfg_ready_out; stores {addr, data, last}. Pushes are allowed in IDLE (prefill) and STREAM.
- States:
  - IDLE: no pops. Outputs held at 0. start_in -> STREAM; word_count cleared; done cleared.
  - STREAM: each edge with FIFO non-empty pops one entry.
    - If the popped addr != 0: register addr/data onto the config outputs for exactly one cycle; word_count +1, saturating at all-ones.
    - If the popped addr == 0: the word is dropped; outputs 0; not counted.
    - If the popped last=1 (either case): -> DONE on the same edge.
    - FIFO empty: outputs 0 that cycle. No stall toward the CGRA; idle cycles are no-ops.
  - DONE: config_done_out=1, outputs 0, ready=0. start_in -> STREAM (count cleared, done cleared). Words behind a last remain buffered and are consumed after the restart.
- abort_in, any state: FIFO flushed, -> IDLE, outputs 0, done cleared; word_count holds.
  - Same-cycle abort_in and start_in: abort wins.
  - Same-cycle abort_in and push: the push is discarded.
- start_in in STREAM: ignored.
- Simultaneous push and pop: legal when not full; occupancy unchanged.
- Latency: a word pushed at edge N into an empty FIFO in STREAM is popped at edge N+1 and visible on the config outputs from N+1 to N+2. Sustained throughput is 1 word/cycle.
- Output registers update only on rising clk_in. The CGRA samples them at the next rising edge.

Optional Feature:
- Macro: CGRA_CFG_PARITY_EN.
- Defined:
  - Adds port cfg_parity_in (input, 1): even parity over {addr, data}. Checked at push.
  - Words that fail the check are dropped, not stored, but still handshaken (ready honoured).
  - Adds port parity_err_out (output, 1): sticky error flag. Cleared by reset, start_in, or abort_in.
  - A failing word carrying last=1 still causes DONE once the FIFO drains ahead of it; it is stored as an addr-0 marker.
- Undefined: neither port exists and no checking is performed.

Test Plan:
- Reset then start; push (0x10,0xAB), (0x14,0xCD), last on (0x18,0xEF) back-to-back -> outputs 0x10/0xAB, 0x14/0xCD, 0x18/0xEF on 3 consecutive cycles, then 0. config_done_out=1, word_count_out=3.
- Prefill 4 words in IDLE -> cfg_ready_out=0 after the 4th. start -> 4 consecutive emissions; ready reasserts one cycle after the first pop.
- Push (0x0,0x55) then (0x20,0x66,last) -> only 0x20/0x66 emitted; word_count_out=1; DONE.
- Mid-stream with 3 buffered: abort_in -> outputs 0 next cycle, state IDLE, FIFO empty. A later start with no pushes -> outputs stay 0.
- Assert reset_in low between clock edges mid-stream -> all outputs 0 immediately (async), before any clock edge; FIFO empty after release.
- CGRA_CFG_PARITY_EN: push a word with a wrong parity bit -> not emitted; parity_err_out=1 until start_in.
